// File: rtl/cache_ref_driver.sv
// Trace-driven initiator for the cache lookup port: fetch reference, look up, allocate on miss, count.
// Optional CACHE_DRV_SATURATE_EN: saturating counters with sticky sat_flag; default build wraps.
module cache_ref_driver #(
    parameter int CNT_W      = 32,
    parameter int LOOKUP_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ref_valid,
    input  logic [31:0]      ref_addr,
    input  logic             ref_last,
    output logic             ref_ready,
    output logic [31:0]      cache_addr,
    output logic             cache_state,
    input  logic             cache_hit,
    output logic [CNT_W-1:0] ref_count,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic             busy,
`ifdef CACHE_DRV_SATURATE_EN
    output logic             sat_flag,
`endif
    output logic             done
);

    typedef enum logic [2:0] {IDLE, FETCH, LOOKUP, UPDATE, DONE} state_t;

    localparam logic [2:0] LAT = 3'(LOOKUP_LAT);

    state_t     state;
    logic       last;
    logic [2:0] wait_cnt;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef CACHE_DRV_SATURATE_EN
        return (&c) ? c : c + CNT_W'(1);
`else
        return c + CNT_W'(1);
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b0;
            wait_cnt    <= '0;
            ref_ready   <= 1'b0;
            cache_addr  <= '0;
            cache_state <= 1'b0;
            ref_count   <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef CACHE_DRV_SATURATE_EN
            sat_flag    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ref_count  <= '0;
                        hit_count  <= '0;
                        miss_count <= '0;
`ifdef CACHE_DRV_SATURATE_EN
                        sat_flag   <= 1'b0;
`endif
                        state      <= FETCH;
                        ref_ready  <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                FETCH: begin
                    if (ref_valid) begin
                        cache_addr <= ref_addr;
                        last       <= ref_last;
                        wait_cnt   <= LAT;
                        ref_ready  <= 1'b0;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // cache_hit is only meaningful in the last wait cycle
                    if (wait_cnt == 3'd1) begin
                        wait_cnt <= '0;
                        if (cache_hit) begin
                            hit_count <= bump(hit_count);
                            ref_count <= bump(ref_count);
`ifdef CACHE_DRV_SATURATE_EN
                            if (&hit_count || &ref_count) sat_flag <= 1'b1;
`endif
                            if (last) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state     <= FETCH;
                                ref_ready <= 1'b1;
                            end
                        end else begin
                            miss_count  <= bump(miss_count);
`ifdef CACHE_DRV_SATURATE_EN
                            if (&miss_count) sat_flag <= 1'b1;
`endif
                            cache_state <= 1'b1;
                            state       <= UPDATE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                UPDATE: begin
                    ref_count   <= bump(ref_count);
`ifdef CACHE_DRV_SATURATE_EN
                    if (&ref_count) sat_flag <= 1'b1;
`endif
                    cache_state <= 1'b0;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= FETCH;
                        ref_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ref_driver.sv
// Bench for cache_ref_driver: two instances (CNT_W=32/LAT=1 and CNT_W=4/LAT=3), vector table, corner sequences, random runs.
module tb_cache_ref_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  start, ref_valid, ref_last, cache_hit;
    logic [31:0] ref_addr [2];
    logic [1:0]  ref_ready, cache_state, busy, done_o;
    logic [31:0] ca0, ca1;
    logic [31:0] rc0, hc0, mc0;
    logic [3:0]  rc1, hc1, mc1;
`ifdef CACHE_DRV_SATURATE_EN
    logic [1:0]  sat;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cache_ref_driver #(.CNT_W(32), .LOOKUP_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .ref_valid(ref_valid[0]), .ref_addr(ref_addr[0]), .ref_last(ref_last[0]),
        .ref_ready(ref_ready[0]), .cache_addr(ca0), .cache_state(cache_state[0]),
        .cache_hit(cache_hit[0]), .ref_count(rc0), .hit_count(hc0), .miss_count(mc0),
        .busy(busy[0]),
`ifdef CACHE_DRV_SATURATE_EN
        .sat_flag(sat[0]),
`endif
        .done(done_o[0])
    );

    cache_ref_driver #(.CNT_W(4), .LOOKUP_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .ref_valid(ref_valid[1]), .ref_addr(ref_addr[1]), .ref_last(ref_last[1]),
        .ref_ready(ref_ready[1]), .cache_addr(ca1), .cache_state(cache_state[1]),
        .cache_hit(cache_hit[1]), .ref_count(rc1), .hit_count(hc1), .miss_count(mc1),
        .busy(busy[1]),
`ifdef CACHE_DRV_SATURATE_EN
        .sat_flag(sat[1]),
`endif
        .done(done_o[1])
    );

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] addr_of(input int k);
        return (k == 0) ? ca0 : ca1;
    endfunction

    // Expected counter value for a raw event count, per instance width and overflow mode
    function automatic logic [31:0] exp_cnt(input int k, input int n);
        if (k == 0) return n;
`ifdef CACHE_DRV_SATURATE_EN
        return (n > 15) ? 32'd15 : n;
`else
        return n % 16;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cnt(input int k, input int r, input int h, input int m, input string tag);
        check({tag, "_ref"},  (k == 0) ? rc0 : {28'd0, rc1}, exp_cnt(k, r));
        check({tag, "_hit"},  (k == 0) ? hc0 : {28'd0, hc1}, exp_cnt(k, h));
        check({tag, "_miss"}, (k == 0) ? mc0 : {28'd0, mc1}, exp_cnt(k, m));
`ifdef CACHE_DRV_SATURATE_EN
        check({tag, "_sat"}, 32'(sat[k]), 32'((k == 1) && (r > 15 || h > 15 || m > 15)));
`endif
    endtask

    task automatic start_run(input int k);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        check("start_busy", 32'(busy[k]), 1);
        check("start_rdy",  32'(ref_ready[k]), 1);
        check("start_done", 32'(done_o[k]), 0);
        check_cnt(k, 0, 0, 0, "start");
    endtask

    // Acts as trace source and cache for one reference; checks address/state/ready timing
    task automatic run_ref(input int k, input logic [31:0] addr, input bit last,
                           input bit hit, input int idle, input bit noise);
        check("pre_rdy", 32'(ref_ready[k]), 1);
        for (int j = 0; j < idle; j++) begin
            ref_valid[k] = 1'b0;
            @(negedge clk);
            check("idle_rdy", 32'(ref_ready[k]), 1);
        end
        ref_valid[k] = 1'b1;
        ref_addr[k]  = addr;
        ref_last[k]  = last;
        @(negedge clk);
        ref_valid[k] = 1'b0;
        ref_addr[k]  = $urandom;
        ref_last[k]  = 1'($urandom);
        for (int i = 1; i <= lat(k); i++) begin
            check("lk_addr",  addr_of(k), addr);
            check("lk_state", 32'(cache_state[k]), 0);
            check("lk_rdy",   32'(ref_ready[k]), 0);
            if (i == lat(k))                 cache_hit[k] = hit;
            else if (noise && i == lat(k)-1) cache_hit[k] = !hit;
            else                             cache_hit[k] = 1'b0;
            @(negedge clk);
        end
        cache_hit[k] = 1'b0;
        if (!hit) begin
            check("upd_state", 32'(cache_state[k]), 1);
            check("upd_addr",  addr_of(k), addr);
            check("upd_rdy",   32'(ref_ready[k]), 0);
            @(negedge clk);
        end
        if (last) begin
            check("end_done", 32'(done_o[k]), 1);
            check("end_busy", 32'(busy[k]), 0);
            check("end_rdy",  32'(ref_ready[k]), 0);
        end else begin
            check("nxt_rdy",  32'(ref_ready[k]), 1);
            check("nxt_busy", 32'(busy[k]), 1);
        end
    endtask

    typedef struct {
        int          k;
        logic [31:0] addr;
        bit          last, hit, noise, new_run;
        int          idle;
        int          er, eh, em;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r, h, m, n;
        bit hb;
        tbl[0] = '{0, 32'h0000_0088, 1, 0, 0, 1, 0, 1, 0, 1};
        tbl[1] = '{0, 32'h0000_0040, 0, 0, 0, 1, 0, 1, 0, 1};
        tbl[2] = '{0, 32'h0000_0040, 1, 1, 0, 0, 0, 2, 1, 1};
        tbl[3] = '{1, 32'h0000_1234, 0, 0, 1, 1, 0, 1, 0, 1};
        tbl[4] = '{1, 32'hFFFF_FFF8, 0, 1, 0, 0, 10, 2, 1, 1};
        tbl[5] = '{1, 32'h0000_0080, 1, 1, 1, 0, 2, 3, 2, 1};

        rst_n = 1'b0; start = '0; ref_valid = '0; ref_last = '0; cache_hit = '0;
        ref_addr[0] = '0; ref_addr[1] = '0;
        @(negedge clk); @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_rdy",   32'(ref_ready[k]), 0);
            check("rst_addr",  addr_of(k), 0);
            check("rst_state", 32'(cache_state[k]), 0);
            check("rst_busy",  32'(busy[k]), 0);
            check("rst_done",  32'(done_o[k]), 0);
            check_cnt(k, 0, 0, 0, "rst");
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            if (tbl[v].new_run) start_run(tbl[v].k);
            run_ref(tbl[v].k, tbl[v].addr, tbl[v].last, tbl[v].hit, tbl[v].idle, tbl[v].noise);
            check_cnt(tbl[v].k, tbl[v].er, tbl[v].eh, tbl[v].em, $sformatf("tbl%0d", v));
        end

        // FETCH stall with a start pulse in the middle: nothing may move
        start_run(0);
        run_ref(0, 32'h0000_0100, 0, 1, 0, 0);
        for (int j = 0; j < 10; j++) begin
            ref_valid[0] = 1'b0;
            start[0] = (j == 4);
            @(negedge clk);
            start[0] = 1'b0;
            check("stall_busy", 32'(busy[0]), 1);
            check("stall_rdy",  32'(ref_ready[0]), 1);
            check_cnt(0, 1, 1, 0, "stall");
        end
        run_ref(0, 32'h0000_0108, 1, 0, 0, 0);
        check_cnt(0, 2, 1, 1, "stall_end");

        // Reset in LOOKUP after three counted references
        start_run(0);
        for (int j = 0; j < 3; j++) run_ref(0, 32'h200 + 32'(j * 8), 0, 1, 0, 0);
        check_cnt(0, 3, 3, 0, "pre_rst");
        ref_valid[0] = 1'b1; ref_addr[0] = 32'h0000_0ABC; ref_last[0] = 1'b0;
        @(negedge clk);
        ref_valid[0] = 1'b0;
        check("mid_addr", ca0, 32'h0000_0ABC);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_rdy",   32'(ref_ready[0]), 0);
        check("mrst_addr",  ca0, 0);
        check("mrst_state", 32'(cache_state[0]), 0);
        check("mrst_busy",  32'(busy[0]), 0);
        check("mrst_done",  32'(done_o[0]), 0);
        check_cnt(0, 0, 0, 0, "mrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(0);
        run_ref(0, 32'h0000_0010, 1, 0, 0, 0);
        check_cnt(0, 1, 0, 1, "post_rst");

        // 17 hits on the 4-bit instance: wrap or saturate
        start_run(1);
        for (int j = 0; j < 17; j++) run_ref(1, 32'(j * 8), j == 16, 1, 0, 0);
        check_cnt(1, 17, 17, 0, "ovf");
`ifdef CACHE_DRV_SATURATE_EN
        check("ovf_hit15", {28'd0, hc1}, 15);
        check("ovf_flag",  32'(sat[1]), 1);
`else
        check("ovf_hit1",  {28'd0, hc1}, 1);
`endif
        start_run(1);
        run_ref(1, 32'h40, 1, 1, 0, 0);
        check_cnt(1, 1, 1, 0, "ovf_restart");

        // Random runs against a simple event-count model
        for (int k = 0; k < 2; k++) begin
            for (int run = 0; run < 20; run++) begin
                start_run(k);
                r = 0; h = 0; m = 0;
                n = $urandom_range(1, 8);
                for (int i = 0; i < n; i++) begin
                    hb = 1'($urandom);
                    run_ref(k, $urandom, i == n - 1, hb, $urandom_range(0, 3), 1'($urandom));
                    r++;
                    if (hb) h++; else m++;
                    check_cnt(k, r, h, m, "rnd");
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
